// File: rtl/dt_proj_mac_pkg.sv
// rtl/dt_proj_mac_pkg.sv - shared Q3.12 datapath constants for the delta projection and softplus stages
package dt_proj_mac_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 12;
  localparam int DT_RANK    = 4;

  // Q3.12 saturation limits shared with the softplus unit
  localparam int SAT_MAX    = 32767;
  localparam int SAT_MIN    = -32768;

endpackage

// File: rtl/q_round_sat.sv
// rtl/q_round_sat.sv - combinational round-half-up, arithmetic shift and saturate to the Q3.12 range
module q_round_sat #(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC      = 12
) (
  input  logic signed [IN_WIDTH-1:0]  val,
  output logic signed [OUT_WIDTH-1:0] q
);
  import dt_proj_mac_pkg::*;

  localparam logic signed [IN_WIDTH-1:0] HALF = IN_WIDTH'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [IN_WIDTH-1:0] HI   = IN_WIDTH'(SAT_MAX);
  localparam logic signed [IN_WIDTH-1:0] LO   = IN_WIDTH'(SAT_MIN);

  logic signed [IN_WIDTH-1:0] rnd;
  logic signed [IN_WIDTH-1:0] shr;

  always_comb begin
    rnd = val + HALF;
    shr = rnd >>> FRAC;
    if (shr > HI) begin
      q = OUT_WIDTH'(SAT_MAX);
    end else if (shr < LO) begin
      q = OUT_WIDTH'(SAT_MIN);
    end else begin
      q = shr[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dt_proj_mac.sv
// rtl/dt_proj_mac.sv - streaming x_dt.w dot product plus bias, producing one saturated Q3.12 delta per transaction
module dt_proj_mac #(
  parameter int DATA_WIDTH = dt_proj_mac_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = dt_proj_mac_pkg::FRAC_BITS,
  parameter int DT_RANK    = dt_proj_mac_pkg::DT_RANK,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bias_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);
  import dt_proj_mac_pkg::*;

  localparam int CNT_W = $clog2(DT_RANK) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DT_RANK - 1);

  typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

  state_t                        state;
  state_t                        state_d;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   fin_sum;
  logic [CNT_W-1:0]              cnt;
  logic [DATA_WIDTH-1:0]         bias_reg;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]  res;
  logic                          beat;

  assign in_ready = (state == ACC);
  assign beat     = in_valid && in_ready;
  assign prod     = $signed(x_in) * $signed(w_in);
  // Bias is aligned to the Q6.24 product scale before rounding back to Q3.12
  assign fin_sum  = acc + (ACC_WIDTH'($signed(bias_reg)) <<< FRAC_BITS);

  q_round_sat #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(DATA_WIDTH),
    .FRAC     (FRAC_BITS)
  ) u_round_sat (
    .val(fin_sum),
    .q  (res)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = ACC;
      ACC:  if (beat && (cnt == LAST)) state_d = FIN;
      FIN:  state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      bias_reg  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_d == OUT);
      busy      <= (state_d != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            bias_reg <= bias_in;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= acc + ACC_WIDTH'(prod);
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIN:     out_data <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_proj_mac.sv
// tb/tb_dt_proj_mac.sv - scoreboard bench for dt_proj_mac against an arithmetic reference model
module tb_dt_proj_mac;

  localparam int DW   = 16;
  localparam int RANK = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] bias_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic [DW-1:0] w_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  always #5 clk = ~clk;

  dt_proj_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias_in  (bias_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] xs[RANK];
  logic [DW-1:0] ws[RANK];
  bit            hold_ready = 0;
  bit            bp_en = 0;
  int            gap_mode = 0;
  logic [6:0]    gap_pat = 7'b1101001;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // dt = sat(floor((sum x*w + bias*2^12 + 2^11) / 2^12))
  function automatic logic [DW-1:0] model(input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(b)) * 4096 + 2048;
    for (int k = 0; k < RANK; k++) s += longint'($signed(xs[k])) * longint'($signed(ws[k]));
    s = s >>> 12;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[DW-1:0];
  endfunction

  task automatic wait_idle();
    int to = 0;
    while (busy && to < 1000) begin
      @(posedge clk); #1;
      to++;
    end
    if (to >= 1000) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_drain();
    int to = 0;
    while ((busy || exp_q.size() != 0) && to < 2000) begin
      @(posedge clk); #1;
      to++;
    end
    if (to >= 2000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic feed_beats(input int nbeats);
    int idx = 0;
    int to = 0;
    int slot = 0;
    bit acc;
    while (idx < nbeats && to < 1000) begin
      case (gap_mode)
        1: in_valid = 1'($urandom_range(0, 1));
        2: in_valid = (slot < 7) ? gap_pat[slot] : 1'b1;
        default: in_valid = 1'b1;
      endcase
      x_in = in_valid ? xs[idx] : DW'($urandom);
      w_in = in_valid ? ws[idx] : DW'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      slot++;
      to++;
    end
    in_valid = 1'b0;
    if (to >= 1000) check("beat_timeout", 32'(idx), 32'(nbeats));
  endtask

  task automatic run_txn(input logic [DW-1:0] b, input bit chk_lat);
    exp_q.push_back(model(b));
    wait_idle();
    start   = 1'b1;
    bias_in = b;
    @(posedge clk); #1;
    start   = 1'b0;
    bias_in = DW'($urandom);
    feed_beats(RANK);
    if (chk_lat) begin
      @(negedge clk);
      check("lat_fin_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_all(input logic [DW-1:0] x, input logic [DW-1:0] w);
    for (int k = 0; k < RANK; k++) begin
      xs[k] = x;
      ws[k] = w;
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_ready ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold stability
  initial begin
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %h expected none", out_data);
          end else begin
            check("result", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bias_in = '0; in_valid = 1'b0; x_in = '0; w_in = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_all(16'h1000, 16'h0800);
    run_txn(16'h0400, 1'b1);
    set_all(16'h7FFF, 16'h7FFF);
    run_txn(16'h7FFF, 1'b0);
    set_all(16'h8000, 16'h7FFF);
    run_txn(16'h8000, 1'b0);
    set_all(16'h0000, 16'h0800);
    xs[0] = 16'h0001;
    run_txn(16'h0000, 1'b0);
    ws[0] = 16'h07FF;
    run_txn(16'h0000, 1'b0);

    gap_mode = 2;
    set_all(16'h1000, 16'h0800);
    run_txn(16'h0400, 1'b0);
    gap_mode = 0;
    wait_drain();

    // Downstream stall with a stray start and stray in_valid that must be ignored
    hold_ready = 1;
    set_all(16'h0C00, 16'hF800);
    run_txn(16'h0200, 1'b0);
    begin
      int to = 0;
      while (!out_valid && to < 20) begin
        @(negedge clk);
        to++;
      end
      check("stall_reach_out", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start    = (i == 1);
      bias_in  = 16'h1234;
      in_valid = 1'b1;
      x_in     = DW'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hDEAD);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    hold_ready = 0;
    set_all(16'h1000, 16'h0800);
    run_txn(16'h0400, 1'b0);
    wait_drain();

    // Asynchronous reset after two accepted beats
    start = 1'b1; bias_in = 16'h0400;
    @(posedge clk); #1;
    start = 1'b0;
    feed_beats(2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(16'h0400, 1'b0);

    // Back-to-back transactions
    for (int t = 0; t < 3; t++) begin
      set_all(DW'(16'h0400 * (t + 1)), DW'(16'h1000 - 16'h0300 * t));
      xs[t] = 16'hF000;
      run_txn(DW'(16'h0100 * t), 1'b0);
    end
    wait_drain();

    // Randomized traffic with gaps and backpressure
    gap_mode = 1;
    bp_en = 1;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < RANK; k++) begin
        xs[k] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 16383) - 8192);
        ws[k] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 16383) - 8192);
      end
      run_txn(DW'($urandom), 1'b0);
    end
    wait_drain();
    bp_en = 0;
    gap_mode = 0;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
